// File: rtl/mul_seq32_pkg.sv
// Shared types and constants for the mul_seq32 iterative multiplier.
package mul_seq32_pkg;

  localparam int unsigned W_DEF = 32;
  localparam int unsigned CNT_W = $clog2(W_DEF);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/mul_seq32_if.sv
// Operand/result handshake bundle for mul_seq32; master drives operands, slave is the multiplier.
interface mul_seq32_if
  import mul_seq32_pkg::*;
#(
  parameter int unsigned W = W_DEF
);

  logic           in_valid_i;
  logic           in_ready_o;
  logic [W-1:0]   A_i;
  logic [W-1:0]   B_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [2*W-1:0] P_o;
  logic           hi_nz_o;

  modport master (
    output in_valid_i, A_i, B_i, out_ready_i,
    input  in_ready_o, out_valid_o, P_o, hi_nz_o
  );

  modport slave (
    input  in_valid_i, A_i, B_i, out_ready_i,
    output in_ready_o, out_valid_o, P_o, hi_nz_o
  );

endinterface

// File: rtl/mul_step.sv
// One radix-2 shift-add step: conditional add of the multiplicand, then a one-bit right shift.
module mul_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] mcand,
  input  logic         lsb,
  output logic [W-1:0] acc_next,
  output logic         shift_out
);

  logic [W:0] sum;

  // The add carry lands in the accumulator MSB after the shift, so nothing is lost.
  always_comb begin
    sum       = {1'b0, acc} + (lsb ? {1'b0, mcand} : '0);
    acc_next  = sum[W:1];
    shift_out = sum[0];
  end

endmodule

// File: rtl/mul_seq32.sv
// Iterative shift-add multiplier (W cycles per product) with valid/ready handshakes.
// Define MUL_SEQ_SIGNED_EN for two's-complement operands and product.
module mul_seq32
  import mul_seq32_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  mul_seq32_if.slave bus
);

  localparam int unsigned CW = $clog2(W);

  state_t         state;
  state_t         state_nxt;
  logic           rdy_en;
  logic           accept;
  logic           last;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mult;
  logic [W-1:0]   acc_nxt;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic           shift_out;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] result;
  logic [2*W-1:0] p_q;
  logic           hi_nz;
  logic           hi_q;

  mul_step #(.W(W)) u_step (
    .acc       (acc),
    .mcand     (mcand),
    .lsb       (mult[0]),
    .acc_next  (acc_nxt),
    .shift_out (shift_out)
  );

  // Product as it will look after the current step; only captured on the last step.
  assign prod = {acc_nxt, shift_out, mult[W-1:1]};

`ifdef MUL_SEQ_SIGNED_EN
  logic neg;

  always_comb begin
    mag_a  = bus.A_i[W-1] ? (~bus.A_i + W'(1)) : bus.A_i;
    mag_b  = bus.B_i[W-1] ? (~bus.B_i + W'(1)) : bus.B_i;
    result = neg ? (~prod + (2*W)'(1)) : prod;
    // Fits in W signed bits only when the top W+1 bits are all equal.
    hi_nz  = ~((&result[2*W-1:W-1]) | ~(|result[2*W-1:W-1]));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      neg <= 1'b0;
    end else if (accept) begin
      neg <= bus.A_i[W-1] ^ bus.B_i[W-1];
    end
  end
`else
  always_comb begin
    mag_a  = bus.A_i;
    mag_b  = bus.B_i;
    result = prod;
    hi_nz  = |result[2*W-1:W];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    last            = 1'b0;
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready_o = rdy_en;
        accept         = rdy_en & bus.in_valid_i;
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        last = (cnt == '0);
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rdy_en keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdy_en <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mult   <= '0;
      p_q    <= '0;
      hi_q   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        mcand <= mag_a;
        mult  <= mag_b;
        acc   <= '0;
        cnt   <= CW'(W - 1);
      end else if (state == RUN) begin
        acc  <= acc_nxt;
        mult <= {shift_out, mult[W-1:1]};
        if (last) begin
          p_q  <= result;
          hi_q <= hi_nz;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

  assign bus.P_o     = p_q;
  assign bus.hi_nz_o = hi_q;

endmodule

// File: doc/mul_seq32.md
MUL_SEQ32 -- requirements
Module: mul_seq32

Interface
REQ-001 Parameter: W, 32, operand width in bits; product width is 2*W.
REQ-002 clk_i  input  1  single clock, all state updates on its rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 in_valid_i  input  1  operand pair on A_i/B_i is valid.
REQ-005 in_ready_o  output  1  block can accept an operand pair.
REQ-006 A_i  input  W  multiplicand.
REQ-007 B_i  input  W  multiplier.
REQ-008 out_valid_o  output  1  P_o holds a finished product.
REQ-009 out_ready_i  input  1  consumer accepts P_o.
REQ-010 P_o  output  2*W  product.
REQ-011 hi_nz_o  output  1  upper W bits of the product are non-zero (32-bit overflow indicator).

Function
REQ-012 The block SHALL be a radix-2 iterative shift-add multiplier with a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: in_ready_o=1; on in_valid_i=1, capture A_i/B_i, clear the accumulator, load the iteration counter with W-1, go to RUN.
REQ-014 RUN: in_ready_o=0; each cycle, conditionally add the multiplicand to the accumulator upper half based on the multiplier LSB, then shift the {carry, accumulator, multiplier} register right one bit.
REQ-015 RUN SHALL last exactly W cycles, with no early termination on zero operands; on counter==0, go to DONE and register the result into P_o.
REQ-016 out_valid_o SHALL rise after exactly W+1 rising edges counted from and including the accepting edge, so the latency is 33 cycles for W=32.
REQ-017 DONE: out_valid_o=1; P_o and hi_nz_o hold stable until out_ready_i=1; on that edge, go to IDLE and drop out_valid_o.
REQ-018 in_ready_o SHALL be 0 in DONE, so there is no accept in the same cycle as the output handshake; the minimum issue interval is W+2 cycles.
REQ-019 in_valid_i and operand changes while in RUN or DONE SHALL be ignored.
REQ-020 Arithmetic SHALL be unsigned and exact over 2*W bits; the carry out of the W-bit add is retained in the shifted register and never lost.
REQ-021 hi_nz_o SHALL equal the OR-reduction of P_o[2W-1:W] and be registered with P_o.

Reset
REQ-022 While rst_n_i=0, the block SHALL enter IDLE immediately and hold the following values: in_ready_o=0, out_valid_o=0, P_o=0, hi_nz_o=0, counter=0, accumulator=0.
REQ-023 in_ready_o SHALL be 1 from the first clock edge after rst_n_i deasserts.
REQ-024 Reset in RUN or DONE SHALL abort the operation and discard its result; no out_valid_o pulse follows.

Configuration
REQ-025 Macro MUL_SEQ_SIGNED_EN: when defined, A_i/B_i/P_o are two's complement.
- Operands are converted to magnitude at capture and the sign XOR is stored.
- The result is negated when it is registered into P_o.
- hi_nz_o flags when P_o does not fit in W signed bits.
- Latency is unchanged.
REQ-026 Without MUL_SEQ_SIGNED_EN, all operands and results are unsigned and the sign logic SHALL be absent.
REQ-027 The most-negative operand (0x80000000) SHALL produce an exact 2*W product under MUL_SEQ_SIGNED_EN.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE), the default width constant 32, and the counter width constant $clog2(32).
REQ-029 The per-cycle add-and-shift datapath SHALL be one combinational sub-module, mul_step, with inputs accumulator, multiplicand and multiplier LSB, and outputs the next accumulator and the shifted-out bit.

Verification
REQ-030 Reset release, then A=3 and B=5 with in_valid=1 -> out_valid rises 33 cycles after the accept edge, P=0x0000_0000_0000_000F, hi_nz=0.
REQ-031 A=0xFFFFFFFF, B=0xFFFFFFFF -> P=0xFFFFFFFE_00000001, hi_nz=1; with MUL_SEQ_SIGNED_EN -> P=0x0000_0000_0000_0001, hi_nz=0.
REQ-032 A=0, B=0x12345678 -> latency still 33, P=0.
REQ-033 Hold out_ready=0 for 10 cycles after done -> P/out_valid stable; in_valid pulses with new operands are ignored; release out_ready -> IDLE next edge, in_ready=1.
REQ-034 Assert rst_n_i=0 asynchronously at cycle 12 of RUN -> outputs go to reset values at once; no out_valid later; the next operation A=7, B=6 gives P=42.
REQ-035 Randomized back-to-back run of 1000 pairs with random out_ready -> every P matches the reference product; issue interval is never under 34 cycles.
